alib_fifo_stream_reader: RTL and testbench
==========================================

Name: alib_fifo_stream_reader

Overview:
- Consumer-side engine for alib_circular_fifo: drives the FIFO read port (rd_en / data_out / empty) and presents the words as a valid/ready stream with framing.
- Absorbs the FIFO's 1-cycle read latency with a 2-entry output buffer, so a stalled downstream never loses a word.
- Groups words into fixed-length bursts and marks the last beat of each burst.
- Sits between a circular FIFO and any downstream stream consumer (DMA, serializer, packetizer).

Parameters:
- WIDTH, 8, data width; must equal the FIFO WIDTH.
- BURST_LEN, 16, beats per burst; must be >= 1.
- CNT_W, $clog2(BURST_LEN+1), width of the beat counter; derived, do not override.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  1 = issue FIFO reads; 0 = stop issuing new reads (in-flight and buffered words still drain).
- fifo_data_out  in  WIDTH  FIFO read data, valid one cycle after fifo_rd_en was high with fifo_empty low.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe.
- m_data  out  WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  high on the final beat of each burst.
- beat_cnt  out  CNT_W  beats accepted in the current burst, 0..BURST_LEN-1.
- burst_done  out  1  one-cycle pulse the cycle after the last beat of a burst is accepted.

Behaviour:
- Reset: one clock and a synchronous, active-high reset (rst). While rst = 1 at a rising edge:
  - fifo_rd_en=0, m_valid=0, m_last=0, m_data=0, beat_cnt=0, burst_done=0;
  - output buffer cleared, in-flight flag cleared.
  - An in-flight word returned during reset is discarded.
- Read issue (combinational):
  - fifo_rd_en = en & ~fifo_empty & ~rst & (occ + inflight - pop < 2).
  - occ = buffer occupancy (0..2); inflight = registered fifo_rd_en; pop = m_valid & m_ready.
  - Guarantees the buffer never overflows. fifo_rd_en is never asserted while fifo_empty = 1.
- Capture: when inflight = 1, fifo_data_out is written into the buffer on the next rising edge. Read latency is exactly 1 cycle; no other latency is supported.
- Output buffer:
  - 2-entry FIFO; head drives m_data.
  - m_valid = (occ != 0).
  - Simultaneous push and pop leaves occ unchanged, and order is preserved.
  - m_data and m_valid hold stable while m_valid & ~m_ready (AXI-style; valid never deasserts without a handshake).
- Throughput: with m_ready held high and FIFO non-empty, one beat per cycle in steady state. First m_valid appears 2 cycles after the first fifo_rd_en, i.e. empty→non-empty to m_valid = 2 cycles.
- Framing:
  - m_last = m_valid & (beat_cnt == BURST_LEN-1).
  - beat_cnt increments on each pop and wraps to 0 on the pop with m_last; burst_done pulses the following cycle.
  - BURST_LEN = 1 gives m_last on every beat and beat_cnt stuck at 0.
- en deassert mid-burst: no new reads issue; buffered and in-flight words are still presented; beat_cnt is retained, so the burst resumes when en returns.
- Reset mid-burst: all state returns to reset values next edge; words already read from the FIFO are lost (documented, not recovered).
- Backpressure with FIFO full upstream: no effect on this block; it simply stops reading when occ + inflight reaches 2.

Decomposition:
- Shared package alib_pkg: no new typedefs required; place the clog2-based width helper there if not already present.
- One natural sub-module: alib_skid_buffer (2-entry, parameter WIDTH, push/pop/occ), reusable by other stream blocks. The reader top holds the issue logic, in-flight flag and beat counter.

Test Plan:
- Basic drain: FIFO preloaded with 16 words 0x10..0x1F, BURST_LEN=16, m_ready=1, en=1 → beats 0x10..0x1F on consecutive cycles after a 2-cycle startup; m_last only on 0x1F; burst_done one cycle later; fifo_rd_en low once empty.
- Backpressure: 4 words 0xA0..0xA3, m_ready toggled 1,0,0,1,... → no word lost or duplicated; m_data held constant while stalled; fifo_rd_en never causes occ > 2.
- Empty guard: fifo_empty=1 for 20 cycles with en=1 → fifo_rd_en=0 and m_valid=0 throughout.
- en pause: 8 words, BURST_LEN=8, en dropped after 3 reads → at most 3 beats out (beat_cnt=3), then stall; en restored → remaining 5 beats, m_last on 8th.
- Reset mid-burst: rst high for 1 cycle after 5 beats accepted → next cycle m_valid=0, beat_cnt=0, fifo_rd_en=0; after release the next burst starts at beat_cnt 0.
- BURST_LEN=1 instance: 3 words → m_last high on every beat, burst_done pulses 3 times.

Source files
------------

// File: rtl/alib_pkg.sv
// Shared definitions for the alib stream blocks: buffer depth and the
// width helper used to size counters and occupancy fields.
package alib_pkg;

    localparam int SKID_DEPTH = 2;

    // Bits needed to hold any value in 0..max_val inclusive (never less than 1).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int OCC_W = cnt_width(SKID_DEPTH);

endpackage

// File: rtl/alib_fifo_stream_reader_if.sv
// FIFO read port plus framed valid/ready stream seen by alib_fifo_stream_reader.
// master = the reader engine, slave = the FIFO / downstream side.
interface alib_fifo_stream_reader_if
    import alib_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = cnt_width(BURST_LEN)
);
    logic             en;
    logic [WIDTH-1:0] fifo_data_out;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic [CNT_W-1:0] beat_cnt;
    logic             burst_done;

    modport master (
        input  en, fifo_data_out, fifo_empty, m_ready,
        output fifo_rd_en, m_data, m_valid, m_last, beat_cnt, burst_done
    );

    modport slave (
        output en, fifo_data_out, fifo_empty, m_ready,
        input  fifo_rd_en, m_data, m_valid, m_last, beat_cnt, burst_done
    );

endinterface

// File: rtl/alib_skid_buffer.sv
// Two-entry in-order buffer with push/pop and occupancy; the head entry is
// always presented on dout so it can back a valid/ready stream directly.
module alib_skid_buffer
    import alib_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [OCC_W-1:0] occ,
    output logic             valid
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [OCC_W-1:0] occ_q;
    logic             pop_ok;

    assign pop_ok = pop & (occ_q != '0);
    assign dout   = head_q;
    assign occ    = occ_q;
    assign valid  = (occ_q != '0);

    // A push into a full buffer with no pop is dropped; the owner's issue
    // logic is expected to make that impossible.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (occ_q == OCC_W'(0)) begin
                        head_q <= din;
                        occ_q  <= OCC_W'(1);
                    end else if (occ_q == OCC_W'(1)) begin
                        tail_q <= din;
                        occ_q  <= OCC_W'(2);
                    end
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ_q  <= occ_q - OCC_W'(1);
                end
                2'b11: begin
                    if (occ_q == OCC_W'(1)) begin
                        head_q <= din;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alib_fifo_stream_reader.sv
// Consumer engine for alib_circular_fifo: issues reads, hides the 1-cycle read
// latency behind a 2-entry skid buffer and frames the stream into bursts.
module alib_fifo_stream_reader
    import alib_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = cnt_width(BURST_LEN)
) (
    input  logic                          clk,
    input  logic                          rst,
    alib_fifo_stream_reader_if.master     bus
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    logic             inflight;
    logic             pop;
    logic             buf_valid;
    logic             last_beat;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   pending;
    logic [WIDTH-1:0] buf_data;
    logic [CNT_W-1:0] beat_q;
    logic             done_q;

    assign pop       = buf_valid & bus.m_ready;
    assign last_beat = buf_valid & (beat_q == LAST_BEAT);

    // Words already committed to the buffer after this edge; a pop guarantees
    // occ >= 1, so the subtraction never wraps.
    assign pending = {1'b0, occ} + (OCC_W+1)'(inflight) - (OCC_W+1)'(pop);

    assign bus.fifo_rd_en = bus.en & ~bus.fifo_empty & ~rst
                          & (pending < (OCC_W+1)'(SKID_DEPTH));

    alib_skid_buffer #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .din   (bus.fifo_data_out),
        .pop   (pop),
        .dout  (buf_data),
        .occ   (occ),
        .valid (buf_valid)
    );

    assign bus.m_data     = buf_data;
    assign bus.m_valid    = buf_valid;
    assign bus.m_last     = last_beat;
    assign bus.beat_cnt   = beat_q;
    assign bus.burst_done = done_q;

    // The beat counter survives en drops so a paused burst resumes in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            beat_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            inflight <= bus.fifo_rd_en;
            done_q   <= pop & last_beat;
            if (pop) begin
                beat_q <= last_beat ? '0 : beat_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alib_fifo_stream_reader.sv
// Randomized self-checking bench for alib_fifo_stream_reader against a queue-based
// model of the FIFO and of the expected stream (burst of 8, plus a burst-of-1 instance).
module tb_alib_fifo_stream_reader;
    import alib_pkg::*;

    localparam int WIDTH = 8;
    localparam int BL    = 8;
    localparam int BL_B  = 1;

    typedef struct {
        logic [WIDTH-1:0] w;
        int               t;
    } rd_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alib_fifo_stream_reader_if #(.WIDTH(WIDTH), .BURST_LEN(BL))   bus_a ();
    alib_fifo_stream_reader_if #(.WIDTH(WIDTH), .BURST_LEN(BL_B)) bus_b ();

    alib_fifo_stream_reader #(.WIDTH(WIDTH), .BURST_LEN(BL)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.master)
    );

    alib_fifo_stream_reader #(.WIDTH(WIDTH), .BURST_LEN(BL_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.master)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cur         = 0;

    logic [WIDTH-1:0] fq_a[$];
    logic [WIDTH-1:0] fq_b[$];
    rd_t              eq[$];
    int               beats;
    logic             last_hs;

    int               s_t;
    logic             s_rst, s_valid, s_ready, s_last, s_bd, s_rd;
    logic [WIDTH-1:0] s_data;
    int               s_bc;
    logic             e_valid, e_last, e_bd, e_rd, e_hs;
    logic [WIDTH-1:0] e_data;
    int               e_bc;
    logic             b_valid, b_last, b_bd, b_rd, b_empty;
    logic [WIDTH-1:0] b_data;
    int               b_bc;

    // Model: the FIFO is a queue; eq holds every word read from it and not yet
    // accepted downstream, tagged with the cycle its read was issued.
    task automatic step();
        rd_t r;
        #1;
        s_t     = cur;
        s_rst   = rst;
        s_valid = bus_a.m_valid;
        s_ready = bus_a.m_ready;
        s_data  = bus_a.m_data;
        s_last  = bus_a.m_last;
        s_bd    = bus_a.burst_done;
        s_rd    = bus_a.fifo_rd_en;
        s_bc    = int'(bus_a.beat_cnt);
        e_valid = (eq.size() != 0) && (eq[0].t + 2 <= cur);
        e_data  = (eq.size() != 0) ? eq[0].w : '0;
        e_bc    = beats % BL;
        e_last  = e_valid && (e_bc == BL - 1);
        e_bd    = last_hs;
        e_hs    = e_valid && s_ready;
        e_rd    = bus_a.en && !bus_a.fifo_empty && !s_rst && ((eq.size() - int'(e_hs)) < 2);
        b_valid = bus_b.m_valid;
        b_data  = bus_b.m_data;
        b_last  = bus_b.m_last;
        b_bd    = bus_b.burst_done;
        b_bc    = int'(bus_b.beat_cnt);
        b_rd    = bus_b.fifo_rd_en;
        b_empty = bus_b.fifo_empty;
        @(posedge clk);
        #1;
        cur++;
        if (s_rst) begin
            eq.delete();
            beats   = 0;
            last_hs = 1'b0;
        end else begin
            if (e_hs) begin
                void'(eq.pop_front());
                beats++;
            end
            last_hs = e_hs && e_last;
        end
        if (s_rd && fq_a.size() != 0) begin
            r.w = fq_a.pop_front();
            r.t = s_t;
            bus_a.fifo_data_out = r.w;
            if (!s_rst) eq.push_back(r);
        end else begin
            bus_a.fifo_data_out = WIDTH'($urandom);
        end
        bus_a.fifo_empty = (fq_a.size() == 0);
        if (b_rd && fq_b.size() != 0) bus_b.fifo_data_out = fq_b.pop_front();
        else bus_b.fifo_data_out = WIDTH'($urandom);
        bus_b.fifo_empty = (fq_b.size() == 0);
    endtask

    task automatic load_a(input logic [WIDTH-1:0] w);
        fq_a.push_back(w);
        bus_a.fifo_empty = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_a.en = 1'b0;
        bus_b.en = 1'b0;
        fq_a.delete();
        fq_b.delete();
        bus_a.fifo_empty = 1'b1;
        bus_b.fifo_empty = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.en = 1'b1;
        bus_a.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) load_a(WIDTH'(8'h50 + i));
        step();
        step();
        vectors++; if (s_rd !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rd_en got %0b want 0", s_rd); end
        vectors++; if (s_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_m_valid got %0b want 0", s_valid); end
        vectors++; if (s_data !== '0) begin miscompares++; $display("[TB] FAIL reset_m_data got %0h want 0", s_data); end
        vectors++; if (s_bc !== 0) begin miscompares++; $display("[TB] FAIL reset_beat_cnt got %0d want 0", s_bc); end
        vectors++; if (s_last !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_m_last got %0b want 0", s_last); end
        vectors++; if (s_bd !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_burst_done got %0b want 0", s_bd); end
    endtask

    task automatic test_basic_drain();
        int first_rd, first_v, last_v, nacc, nlast, nbd;
        do_reset();
        bus_a.m_ready = 1'b1;
        bus_a.en = 1'b1;
        for (int i = 0; i < 16; i++) load_a(WIDTH'(8'h10 + i));
        first_rd = -1; first_v = -1; last_v = -1; nacc = 0; nlast = 0; nbd = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (s_rd && first_rd < 0) first_rd = s_t;
            if (s_valid && s_ready) begin
                nacc++;
                if (first_v < 0) first_v = s_t;
                last_v = s_t;
                if (s_last) nlast++;
            end
            if (s_bd) nbd++;
            vectors++; if (s_valid !== e_valid) begin miscompares++; $display("[TB] FAIL drain_valid t=%0d got %0b want %0b", s_t, s_valid, e_valid); end
            if (e_valid) begin
                vectors++; if (s_data !== e_data) begin miscompares++; $display("[TB] FAIL drain_data t=%0d got %0h want %0h", s_t, s_data, e_data); end
            end
            vectors++; if (s_last !== e_last) begin miscompares++; $display("[TB] FAIL drain_last t=%0d got %0b want %0b", s_t, s_last, e_last); end
            vectors++; if (s_bd !== e_bd) begin miscompares++; $display("[TB] FAIL drain_burst_done t=%0d got %0b want %0b", s_t, s_bd, e_bd); end
            vectors++; if (s_rd !== e_rd) begin miscompares++; $display("[TB] FAIL drain_rd_en t=%0d got %0b want %0b", s_t, s_rd, e_rd); end
        end
        vectors++; if (first_v - first_rd != 2) begin miscompares++; $display("[TB] FAIL drain_latency got %0d want 2", first_v - first_rd); end
        vectors++; if (last_v - first_v != 15) begin miscompares++; $display("[TB] FAIL drain_back_to_back span got %0d want 15", last_v - first_v); end
        vectors++; if (nacc != 16) begin miscompares++; $display("[TB] FAIL drain_beats got %0d want 16", nacc); end
        vectors++; if (nlast != 2) begin miscompares++; $display("[TB] FAIL drain_last_count got %0d want 2", nlast); end
        vectors++; if (nbd != 2) begin miscompares++; $display("[TB] FAIL drain_done_count got %0d want 2", nbd); end
    endtask

    task automatic test_backpressure();
        int nacc;
        do_reset();
        bus_a.en = 1'b1;
        for (int i = 0; i < 4; i++) load_a(WIDTH'(8'hA0 + i));
        nacc = 0;
        for (int i = 0; i < 30; i++) begin
            bus_a.m_ready = (i % 3 == 0);
            step();
            if (s_valid && s_ready) nacc++;
            vectors++; if (s_valid !== e_valid) begin miscompares++; $display("[TB] FAIL bp_valid t=%0d got %0b want %0b", s_t, s_valid, e_valid); end
            if (e_valid) begin
                vectors++; if (s_data !== e_data) begin miscompares++; $display("[TB] FAIL bp_data t=%0d got %0h want %0h", s_t, s_data, e_data); end
            end
            vectors++; if (s_rd !== e_rd) begin miscompares++; $display("[TB] FAIL bp_rd_en t=%0d got %0b want %0b", s_t, s_rd, e_rd); end
            vectors++; if (eq.size() > 2) begin miscompares++; $display("[TB] FAIL bp_occupancy t=%0d got %0d want <=2", s_t, eq.size()); end
        end
        vectors++; if (nacc != 4) begin miscompares++; $display("[TB] FAIL bp_beats got %0d want 4", nacc); end
    endtask

    task automatic test_empty_guard();
        do_reset();
        bus_a.en = 1'b1;
        bus_a.m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            vectors++; if (s_rd !== 1'b0) begin miscompares++; $display("[TB] FAIL empty_rd_en t=%0d got %0b want 0", s_t, s_rd); end
            vectors++; if (s_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL empty_valid t=%0d got %0b want 0", s_t, s_valid); end
        end
    endtask

    task automatic test_en_pause();
        int reads, nlast, guard;
        do_reset();
        bus_a.m_ready = 1'b1;
        bus_a.en = 1'b1;
        for (int i = 0; i < 8; i++) load_a(WIDTH'($urandom));
        reads = 0; nlast = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (s_rd) reads++;
            if (reads == 3) bus_a.en = 1'b0;
            vectors++; if (s_valid !== e_valid) begin miscompares++; $display("[TB] FAIL pause_valid t=%0d got %0b want %0b", s_t, s_valid, e_valid); end
            if (e_valid) begin
                vectors++; if (s_data !== e_data) begin miscompares++; $display("[TB] FAIL pause_data t=%0d got %0h want %0h", s_t, s_data, e_data); end
            end
            vectors++; if (s_rd !== e_rd) begin miscompares++; $display("[TB] FAIL pause_rd_en t=%0d got %0b want %0b", s_t, s_rd, e_rd); end
        end
        vectors++; if (s_bc !== 3) begin miscompares++; $display("[TB] FAIL pause_beat_cnt got %0d want 3", s_bc); end
        vectors++; if (s_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL pause_stalled_valid got %0b want 0", s_valid); end
        vectors++; if (fq_a.size() != 5) begin miscompares++; $display("[TB] FAIL pause_fifo_level got %0d want 5", fq_a.size()); end
        bus_a.en = 1'b1;
        guard = 0;
        while ((fq_a.size() != 0 || eq.size() != 0) && guard < 20) begin
            step();
            guard++;
            if (s_valid && s_ready && s_last) nlast++;
            vectors++; if (s_valid !== e_valid) begin miscompares++; $display("[TB] FAIL resume_valid t=%0d got %0b want %0b", s_t, s_valid, e_valid); end
            if (e_valid) begin
                vectors++; if (s_data !== e_data) begin miscompares++; $display("[TB] FAIL resume_data t=%0d got %0h want %0h", s_t, s_data, e_data); end
            end
            vectors++; if (s_bc !== e_bc) begin miscompares++; $display("[TB] FAIL resume_beat_cnt t=%0d got %0d want %0d", s_t, s_bc, e_bc); end
            vectors++; if (s_last !== e_last) begin miscompares++; $display("[TB] FAIL resume_last t=%0d got %0b want %0b", s_t, s_last, e_last); end
        end
        vectors++; if (guard >= 20) begin miscompares++; $display("[TB] FAIL resume_timeout got %0d cycles want <20", guard); end
        vectors++; if (beats != 8 || nlast != 1) begin miscompares++; $display("[TB] FAIL resume_burst beats=%0d lasts=%0d want 8 and 1", beats, nlast); end
    endtask

    task automatic test_reset_mid_burst();
        int guard;
        do_reset();
        bus_a.m_ready = 1'b1;
        bus_a.en = 1'b1;
        for (int i = 0; i < 12; i++) load_a(WIDTH'($urandom));
        guard = 0;
        while (beats < 5 && guard < 20) begin
            step();
            guard++;
            if (e_valid) begin
                vectors++; if (s_data !== e_data) begin miscompares++; $display("[TB] FAIL midrst_data t=%0d got %0h want %0h", s_t, s_data, e_data); end
            end
        end
        vectors++; if (guard >= 20) begin miscompares++; $display("[TB] FAIL midrst_timeout got %0d cycles want <20", guard); end
        rst = 1'b1;
        step();
        vectors++; if (s_rd !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_rd_en got %0b want 0", s_rd); end
        rst = 1'b0;
        step();
        vectors++; if (s_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_valid got %0b want 0", s_valid); end
        vectors++; if (s_bc !== 0) begin miscompares++; $display("[TB] FAIL midrst_beat_cnt got %0d want 0", s_bc); end
        guard = 0;
        while ((fq_a.size() != 0 || eq.size() != 0) && guard < 30) begin
            step();
            guard++;
            vectors++; if (s_valid !== e_valid) begin miscompares++; $display("[TB] FAIL postrst_valid t=%0d got %0b want %0b", s_t, s_valid, e_valid); end
            if (e_valid) begin
                vectors++; if (s_data !== e_data) begin miscompares++; $display("[TB] FAIL postrst_data t=%0d got %0h want %0h", s_t, s_data, e_data); end
            end
            vectors++; if (s_bc !== e_bc) begin miscompares++; $display("[TB] FAIL postrst_beat_cnt t=%0d got %0d want %0d", s_t, s_bc, e_bc); end
            vectors++; if (s_last !== e_last) begin miscompares++; $display("[TB] FAIL postrst_last t=%0d got %0b want %0b", s_t, s_last, e_last); end
        end
        vectors++; if (guard >= 30) begin miscompares++; $display("[TB] FAIL postrst_timeout got %0d cycles want <30", guard); end
    endtask

    task automatic test_random_soak();
        int n;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++) load_a(WIDTH'($urandom));
            end
            bus_a.en      = ($urandom_range(0, 7) != 0);
            bus_a.m_ready = ($urandom_range(0, 3) != 0);
            step();
            vectors++; if (s_valid !== e_valid) begin miscompares++; $display("[TB] FAIL soak_valid t=%0d got %0b want %0b", s_t, s_valid, e_valid); end
            if (e_valid) begin
                vectors++; if (s_data !== e_data) begin miscompares++; $display("[TB] FAIL soak_data t=%0d got %0h want %0h", s_t, s_data, e_data); end
            end
            vectors++; if (s_last !== e_last) begin miscompares++; $display("[TB] FAIL soak_last t=%0d got %0b want %0b", s_t, s_last, e_last); end
            vectors++; if (s_bc !== e_bc) begin miscompares++; $display("[TB] FAIL soak_beat_cnt t=%0d got %0d want %0d", s_t, s_bc, e_bc); end
            vectors++; if (s_bd !== e_bd) begin miscompares++; $display("[TB] FAIL soak_burst_done t=%0d got %0b want %0b", s_t, s_bd, e_bd); end
            vectors++; if (s_rd !== e_rd) begin miscompares++; $display("[TB] FAIL soak_rd_en t=%0d got %0b want %0b", s_t, s_rd, e_rd); end
        end
        bus_a.en = 1'b1;
        bus_a.m_ready = 1'b1;
        for (int i = 0; i < 80; i++) step();
        vectors++; if (s_valid !== 1'b0 || eq.size() != 0 || fq_a.size() != 0) begin miscompares++; $display("[TB] FAIL soak_drain valid=%0b pending=%0d fifo=%0d want all 0", s_valid, eq.size(), fq_a.size()); end
    endtask

    task automatic test_burst_len1();
        logic [WIDTH-1:0] expw[$];
        logic [WIDTH-1:0] w;
        int nlast, nbd;
        do_reset();
        bus_b.m_ready = 1'b1;
        bus_b.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w = WIDTH'($urandom);
            fq_b.push_back(w);
            expw.push_back(w);
        end
        bus_b.fifo_empty = 1'b0;
        nlast = 0; nbd = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (b_bd) nbd++;
            vectors++; if (b_bc !== 0) begin miscompares++; $display("[TB] FAIL bl1_beat_cnt t=%0d got %0d want 0", s_t, b_bc); end
            vectors++; if (b_rd && b_empty) begin miscompares++; $display("[TB] FAIL bl1_rd_on_empty t=%0d got 1 want 0", s_t); end
            if (b_valid) begin
                nlast += int'(b_last);
                vectors++; if (b_last !== 1'b1) begin miscompares++; $display("[TB] FAIL bl1_last t=%0d got %0b want 1", s_t, b_last); end
                vectors++;
                if (expw.size() == 0) begin miscompares++; $display("[TB] FAIL bl1_extra_beat t=%0d got %0h want none", s_t, b_data); end
                else begin
                    w = expw.pop_front();
                    if (b_data !== w) begin miscompares++; $display("[TB] FAIL bl1_data t=%0d got %0h want %0h", s_t, b_data, w); end
                end
            end
        end
        vectors++; if (nlast != 3) begin miscompares++; $display("[TB] FAIL bl1_last_count got %0d want 3", nlast); end
        vectors++; if (nbd != 3) begin miscompares++; $display("[TB] FAIL bl1_done_count got %0d want 3", nbd); end
        vectors++; if (expw.size() != 0) begin miscompares++; $display("[TB] FAIL bl1_missing got %0d words left want 0", expw.size()); end
    endtask

    initial begin
        rst = 1'b1;
        beats = 0;
        last_hs = 1'b0;
        bus_a.en = 1'b0;
        bus_a.m_ready = 1'b0;
        bus_a.fifo_empty = 1'b1;
        bus_a.fifo_data_out = '0;
        bus_b.en = 1'b0;
        bus_b.m_ready = 1'b0;
        bus_b.fifo_empty = 1'b1;
        bus_b.fifo_data_out = '0;
        test_reset();
        test_basic_drain();
        test_backpressure();
        test_empty_guard();
        test_en_pause();
        test_reset_mid_burst();
        test_random_soak();
        test_burst_len1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
